rob_commit_ctrl: RTL and testbench

Sequencing controller for the 8-entry `reorder_buffer`. It shares the ROB's single result-write port between two writeback requesters with round-robin arbitration. It retires the head entry in order, writing the destination register and popping it. On a branch misprediction it flushes the ROB and redirects fetch. It sits between the execution units/CDB, the ROB, the register file and the fetch stage.

---
 rtl/rob_commit_ctrl.sv | 149 ++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// ROB sequencer: round-robin writeback arbitration, in-order retire, mispredict flush/redirect.
// Latency: grants combinational; commit pulses one cycle after head ready, flush one cycle after that.
// Backpressure: losing requester simply stays ungranted; no grants during FLUSH/RECOVER. Option: ROB_CTRL_PERF_EN.
module rob_commit_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wb0_req,
    input  logic [ADDR_WIDTH-1:0] wb0_addr,
    input  logic [DATA_WIDTH-1:0] wb0_value,
    input  logic                  wb1_req,
    input  logic [ADDR_WIDTH-1:0] wb1_addr,
    input  logic [DATA_WIDTH-1:0] wb1_value,
    output logic                  wb0_gnt,
    output logic                  wb1_gnt,
    output logic [ADDR_WIDTH-1:0] rob_addr,
    output logic [DATA_WIDTH-1:0] rob_value,
    output logic                  rob_ld_value,
    output logic                  rob_ld_busy,
    output logic                  rob_re,
    output logic                  rob_flush,
    input  logic                  rob_empty,
    input  logic                  head_busy,
    input  logic                  head_valid,
    input  logic                  head_predict,
    input  logic [REG_WIDTH-1:0]  head_tag,
    input  logic [15:0]           head_inst,
    input  logic [DATA_WIDTH-1:0] head_value,
    output logic                  rf_we,
    output logic [REG_WIDTH-1:0]  rf_dest,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc
`ifdef ROB_CTRL_PERF_EN
    ,
    output logic [15:0]           commit_count,
    output logic [15:0]           mispredict_count
`endif
);

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, RECOVER} state_t;

    state_t     state;
    logic       rr;
    logic       lat_mispredict;
    logic       grant_en;
    logic       both_req;
    logic       head_ready;
    logic [3:0] opcode;
    logic       is_br;
    logic       no_wb;
    logic       mispredict;
    logic       unused_inst;

    assign opcode      = head_inst[15:12];
    assign unused_inst = ^head_inst[11:0];
    assign is_br       = (opcode == 4'b0000);
    assign no_wb       = is_br || (opcode == 4'b0011) || (opcode == 4'b0111) || (opcode == 4'b1011);
    // Branch results carry the actual-taken flag in the LSB of the (word-aligned) next PC.
    assign mispredict  = head_valid && is_br && (head_value[0] != head_predict);
    assign head_ready  = !rob_empty && !head_busy;

    assign grant_en = reset_n && (state != FLUSH) && (state != RECOVER);
    assign both_req = wb0_req && wb1_req;

    always_comb begin
        wb0_gnt = 1'b0;
        wb1_gnt = 1'b0;
        if (grant_en) begin
            if (both_req) begin
                wb0_gnt = !rr;
                wb1_gnt = rr;
            end else begin
                wb0_gnt = wb0_req;
                wb1_gnt = wb1_req;
            end
        end
    end

    assign rob_addr     = wb1_gnt ? wb1_addr  : wb0_addr;
    assign rob_value    = wb1_gnt ? wb1_value : wb0_value;
    assign rob_ld_value = wb0_gnt || wb1_gnt;
    assign rob_ld_busy  = rob_ld_value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rr             <= 1'b0;
            lat_mispredict <= 1'b0;
            rob_re         <= 1'b0;
            rob_flush      <= 1'b0;
            rf_we          <= 1'b0;
            rf_dest        <= '0;
            rf_data        <= '0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            rob_re    <= 1'b0;
            rf_we     <= 1'b0;
            rob_flush <= 1'b0;
            redirect  <= 1'b0;
            if (grant_en && both_req)
                rr <= ~rr;
            case (state)
                IDLE: begin
                    if (head_ready) begin
                        state          <= COMMIT;
                        rob_re         <= 1'b1;
                        rf_we          <= head_valid && !no_wb;
                        rf_dest        <= head_tag;
                        rf_data        <= head_value;
                        lat_mispredict <= mispredict;
                    end
                end
                COMMIT: begin
                    if (lat_mispredict) begin
                        state       <= FLUSH;
                        rob_flush   <= 1'b1;
                        redirect    <= 1'b1;
                        redirect_pc <= {rf_data[DATA_WIDTH-1:1], 1'b0};
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH:   state <= RECOVER;
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROB_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (rob_re && (commit_count != 16'hFFFF))
                commit_count <= commit_count + 16'd1;
            if (rob_flush && (mispredict_count != 16'hFFFF))
                mispredict_count <= mispredict_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: cycle-schedule reference model checked every cycle, plus directed literal checks.
module tb_rob_commit_ctrl;
    localparam int DW = 16, AW = 3, RW = 3, MAXC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic wb0_req, wb1_req;
    logic [AW-1:0] wb0_addr, wb1_addr;
    logic [DW-1:0] wb0_value, wb1_value;
    logic wb0_gnt, wb1_gnt;
    logic [AW-1:0] rob_addr;
    logic [DW-1:0] rob_value;
    logic rob_ld_value, rob_ld_busy, rob_re, rob_flush;
    logic rob_empty, head_busy, head_valid, head_predict;
    logic [RW-1:0] head_tag;
    logic [15:0] head_inst;
    logic [DW-1:0] head_value;
    logic rf_we;
    logic [RW-1:0] rf_dest;
    logic [DW-1:0] rf_data;
    logic redirect;
    logic [DW-1:0] redirect_pc;
`ifdef ROB_CTRL_PERF_EN
    logic [15:0] commit_count, mispredict_count;
`endif

    rob_commit_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb0_req(wb0_req), .wb0_addr(wb0_addr), .wb0_value(wb0_value),
        .wb1_req(wb1_req), .wb1_addr(wb1_addr), .wb1_value(wb1_value),
        .wb0_gnt(wb0_gnt), .wb1_gnt(wb1_gnt),
        .rob_addr(rob_addr), .rob_value(rob_value),
        .rob_ld_value(rob_ld_value), .rob_ld_busy(rob_ld_busy),
        .rob_re(rob_re), .rob_flush(rob_flush), .rob_empty(rob_empty),
        .head_busy(head_busy), .head_valid(head_valid), .head_predict(head_predict),
        .head_tag(head_tag), .head_inst(head_inst), .head_value(head_value),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef ROB_CTRL_PERF_EN
        , .commit_count(commit_count), .mispredict_count(mispredict_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a per-cycle schedule of the pulses each accepted head must produce.
    bit            m_re   [MAXC];
    bit            m_we   [MAXC];
    bit            m_fl   [MAXC];
    bit            m_ng   [MAXC];
    logic [RW-1:0] m_dest [MAXC];
    logic [DW-1:0] m_data [MAXC];
    logic [DW-1:0] m_rpc  [MAXC];
    bit            m_rr = 1'b0;
    int            next_acc = 0;
    int            m_commits = 0;
    int            m_flushes = 0;

    always @(negedge clk) begin
        bit allow, e0, e1, mp, wb;
        logic [3:0] op;
        if (!reset_n) begin
            chk("rst_gnt0", wb0_gnt, 0);
            chk("rst_gnt1", wb1_gnt, 0);
            chk("rst_ld", {rob_ld_value, rob_ld_busy}, 0);
            chk("rst_pulses", {rob_re, rob_flush, rf_we, redirect}, 0);
            chk("rst_rf_dest", rf_dest, 0);
            chk("rst_rf_data", rf_data, 0);
            chk("rst_redirect_pc", redirect_pc, 0);
            m_rr = 1'b0;
            m_commits = 0;
            m_flushes = 0;
            for (int k = cyc; k < cyc + 5; k++) begin
                m_re[k] = 0; m_we[k] = 0; m_fl[k] = 0; m_ng[k] = 0;
            end
            next_acc = cyc + 1;
        end else begin
            allow = !m_ng[cyc];
            e0 = 0; e1 = 0;
            if (allow) begin
                if (wb0_req && wb1_req) begin
                    if (m_rr) e1 = 1; else e0 = 1;
                    m_rr = !m_rr;
                end else begin
                    e0 = wb0_req;
                    e1 = wb1_req;
                end
            end
            chk("gnt0", wb0_gnt, e0);
            chk("gnt1", wb1_gnt, e1);
            chk("ld_value", rob_ld_value, e0 | e1);
            chk("ld_busy", rob_ld_busy, e0 | e1);
            if (e0) begin chk("rob_addr", rob_addr, wb0_addr); chk("rob_value", rob_value, wb0_value); end
            if (e1) begin chk("rob_addr", rob_addr, wb1_addr); chk("rob_value", rob_value, wb1_value); end
            chk("rob_re", rob_re, m_re[cyc]);
            chk("rf_we", rf_we, m_we[cyc]);
            if (m_we[cyc]) begin
                chk("rf_dest", rf_dest, m_dest[cyc]);
                chk("rf_data", rf_data, m_data[cyc]);
            end
            chk("rob_flush", rob_flush, m_fl[cyc]);
            chk("redirect", redirect, m_fl[cyc]);
            if (m_fl[cyc]) chk("redirect_pc", redirect_pc, m_rpc[cyc]);
            if (m_re[cyc]) m_commits++;
            if (m_fl[cyc]) m_flushes++;
            if (cyc >= next_acc && !rob_empty && !head_busy) begin
                op = head_inst[15:12];
                wb = !(op == 4'd0 || op == 4'd3 || op == 4'd7 || op == 4'd11);
                mp = head_valid && (op == 4'd0) && (head_value[0] != head_predict);
                m_re[cyc+1] = 1;
                m_we[cyc+1] = head_valid && wb;
                m_dest[cyc+1] = head_tag;
                m_data[cyc+1] = head_value;
                if (mp) begin
                    m_fl[cyc+2] = 1;
                    m_rpc[cyc+2] = head_value & ~16'd1;
                    m_ng[cyc+2] = 1;
                    m_ng[cyc+3] = 1;
                    next_acc = cyc + 4;
                end else begin
                    next_acc = cyc + 2;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic [15:0] inst, input logic [RW-1:0] tag,
                            input logic [DW-1:0] val, input logic vld, input logic pred);
        head_inst = inst; head_tag = tag; head_value = val;
        head_valid = vld; head_predict = pred;
        head_busy = 0; rob_empty = 0;
    endtask

    logic [3:0] ops [10];

    initial begin
        ops = '{4'd0, 4'd0, 4'd0, 4'd3, 4'd7, 4'd11, 4'd1, 4'd2, 4'd5, 4'd9};
        reset_n = 0;
        wb0_req = 1; wb1_req = 0; wb0_addr = 0; wb1_addr = 0; wb0_value = 0; wb1_value = 0;
        rob_empty = 1; head_busy = 0; head_valid = 0; head_predict = 0;
        head_tag = 0; head_inst = 0; head_value = 0;

        // Reset with wb0 requesting, then release
        repeat (3) step();
        @(negedge clk);
        chk("d_rst_gnt0", wb0_gnt, 0);
        chk("d_rst_re", rob_re, 0);
        step();
        reset_n = 1;
        @(negedge clk);
        chk("d_release_gnt0", wb0_gnt, 1);

        // Contention: alternating grants
        step();
        wb1_req = 1; wb0_addr = 1; wb1_addr = 2; wb0_value = 16'h0100; wb1_value = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("d_cont_gnt0", wb0_gnt, (i % 2 == 0) ? 1 : 0);
            chk("d_cont_addr", rob_addr, (i % 2 == 0) ? 1 : 2);
            step();
        end
        wb0_req = 0; wb1_req = 0;

        // Plain commit of ADD
        set_head(16'h1042, 3'd3, 16'd20, 1, 0);
        step();
        rob_empty = 1;
        @(negedge clk);
        chk("d_add_re", rob_re, 1);
        chk("d_add_we", rf_we, 1);
        chk("d_add_dest", rf_dest, 3);
        chk("d_add_data", rf_data, 20);
        step(); step();

        // Store retires without a register write
        set_head(16'h7040, 3'd2, 16'd9, 1, 0);
        step();
        rob_empty = 1;
        @(negedge clk);
        chk("d_str_re", rob_re, 1);
        chk("d_str_we", rf_we, 0);
        step(); step();

        // Squashed mispredicting branch: popped, no flush
        set_head(16'h0000, 3'd1, 16'h3011, 0, 0);
        step();
        rob_empty = 1;
        @(negedge clk);
        chk("d_sq_re", rob_re, 1);
        chk("d_sq_we", rf_we, 0);
        step();
        @(negedge clk);
        chk("d_sq_flush", rob_flush, 0);
        step();

        // Mispredicted branch: flush, redirect, two grant-free cycles
        wb0_req = 1; wb0_addr = 5;
        set_head(16'h0000, 3'd1, 16'h3011, 1, 0);
        step();
        rob_empty = 1;
        @(negedge clk);
        chk("d_mp_re", rob_re, 1);
        step();
        @(negedge clk);
        chk("d_mp_flush", rob_flush, 1);
        chk("d_mp_redirect", redirect, 1);
        chk("d_mp_pc", redirect_pc, 16'h3010);
        chk("d_mp_gnt_flush", wb0_gnt, 0);
        step();
        @(negedge clk);
        chk("d_mp_gnt_recover", wb0_gnt, 0);
        step();
        @(negedge clk);
        chk("d_mp_gnt_idle", wb0_gnt, 1);
        wb0_req = 0;
        step();

        // Busy head waits for its writeback
        set_head(16'h1042, 3'd5, 16'd7, 1, 0);
        head_busy = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("d_busy_re", rob_re, 0);
            step();
        end
        wb0_req = 1; wb0_addr = 4;
        @(negedge clk);
        chk("d_busy_gnt", wb0_gnt, 1);
        step();
        wb0_req = 0; head_busy = 0;
        step();
        rob_empty = 1;
        @(negedge clk);
        chk("d_busy_re_after", rob_re, 1);
        chk("d_busy_dest", rf_dest, 5);
        step();

        // Reset in the middle of a mispredict commit aborts it
        set_head(16'h0000, 3'd1, 16'h0040, 1, 1);
        step();
        rob_empty = 1; reset_n = 0;
        @(negedge clk);
        chk("d_abort_re", rob_re, 0);
        step();
        reset_n = 1;
        @(negedge clk);
        chk("d_abort_flush", rob_flush, 0);
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            wb0_req = $urandom_range(0, 1);
            wb1_req = $urandom_range(0, 1);
            wb0_addr = AW'($urandom);
            wb1_addr = AW'($urandom);
            wb0_value = DW'($urandom);
            wb1_value = DW'($urandom);
            rob_empty = ($urandom_range(0, 9) < 3);
            head_busy = ($urandom_range(0, 9) < 3);
            head_valid = ($urandom_range(0, 9) < 8);
            head_predict = $urandom_range(0, 1);
            head_tag = RW'($urandom);
            head_inst = {ops[$urandom_range(0, 9)], 12'($urandom)};
            head_value = DW'($urandom);
            step();
        end
        rob_empty = 1; wb0_req = 0; wb1_req = 0;
        repeat (5) step();
`ifdef ROB_CTRL_PERF_EN
        @(negedge clk);
        chk("perf_commits", commit_count, m_commits);
        chk("perf_mispredicts", mispredict_count, m_flushes);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
